aes_dec_round_ctrl: RTL and testbench

Iterative sequencer for the AES-128 inverse cipher. It accepts a ciphertext block over a valid/ready handshake and holds the 128-bit state register. It drives the external combinational inverse-round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) for one round per clock, selecting the round key from the expanded-key bundle. It returns the plaintext over a second valid/ready handshake, replacing the free-running, X-gated round loop with a deterministic FSM.

---
 rtl/aes_dec_round_ctrl.sv | 135 +++++++++++++
 tb/tb_aes_dec_round_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_round_ctrl.sv
// AES-128 inverse-cipher round sequencer: one external inverse round per clock.
// Optional key-bundle latch on accept: define AES_DEC_KEY_LATCH_EN.
module aes_dec_round_ctrl #(
  parameter int NR = 10,
  parameter int KW = 128*(NR+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [KW-1:0] words,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic [127:0]  rnd_state,
  output logic [127:0]  rnd_key,
  output logic          rnd_last,
  input  logic [127:0]  rnd_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } st_t;

  st_t          st_q;
  st_t          st_d;
  logic [127:0] state_q;
  logic [127:0] out_data_q;
  logic [3:0]   cnt_q;
  logic         out_valid_q;
  logic         accept;
  logic [KW-1:0] key_src;
  logic [127:0] key_arr [0:NR];
  logic [127:0] live_last_key;

  assign accept        = (st_q == IDLE) && in_valid;
  assign live_last_key = words[KW-1-128*NR -: 128];

`ifdef AES_DEC_KEY_LATCH_EN
  logic [KW-1:0] key_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q <= '0;
    end else if (accept) begin
      key_q <= words;
    end
  end

  assign key_src = key_q;
`else
  assign key_src = words;
`endif

  for (genvar r = 0; r <= NR; r++) begin : g_key
    assign key_arr[r] = key_src[KW-1-128*r -: 128];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:  if (in_valid) st_d = ROUND;
      ROUND: if (cnt_q == 4'd1) st_d = FINAL;
      FINAL: st_d = DONE;
      DONE:  if (out_ready) st_d = IDLE;
    endcase
  end

  // Round keys are consumed from key NR-1 down to key 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= in_data ^ live_last_key;
            cnt_q   <= 4'(NR-1);
          end
        end
        ROUND: begin
          state_q <= rnd_result;
          cnt_q   <= cnt_q - 4'd1;
        end
        FINAL: begin
          out_data_q  <= rnd_result;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    rnd_last = 1'b0;
    rnd_key  = key_arr[0];
    unique case (1'b1)
      (st_q == IDLE):  in_ready = 1'b1;
      (st_q == ROUND): begin
        busy    = 1'b1;
        rnd_key = key_arr[cnt_q];
      end
      (st_q == FINAL): begin
        busy     = 1'b1;
        rnd_last = 1'b1;
      end
      (st_q == DONE):  ;
    endcase
  end

  assign rnd_state = state_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl with a behavioural inverse-round datapath.
// Directed FIPS-197 C.1 vectors plus handshake, reset and key-hold cases.
module tb_aes_dec_round_ctrl;

  localparam int KW = 1408;

  logic          clk;
  logic          rst_n;
  logic [KW-1:0] words;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic [127:0]  rnd_state;
  logic [127:0]  rnd_key;
  logic          rnd_last;
  logic [127:0]  rnd_result;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic          busy;

  int errs   = 0;
  int checks = 0;

  aes_dec_round_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .words      (words),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .rnd_state  (rnd_state),
    .rnd_key    (rnd_key),
    .rnd_last   (rnd_last),
    .rnd_result (rnd_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] p = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] s);
    return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r+4*c] = isbox(b[r+4*((c-r+4)%4)]) ^ k[127-8*(r+4*c) -: 8];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09);
        t[4*c+1] = gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d);
        t[4*c+2] = gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b);
        t[4*c+3] = gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  function automatic logic [KW-1:0] expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [KW-1:0] bnd;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) bnd[KW-1-32*i -: 32] = w[i];
    return bnd;
  endfunction

  function automatic logic [127:0] rk(input logic [KW-1:0] bnd, input int r);
    return bnd[KW-1-128*r -: 128];
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] ct,
                                       input logic [KW-1:0] b0,
                                       input logic [KW-1:0] br);
    logic [127:0] s = ct ^ rk(b0, 10);
    for (int r = 9; r >= 1; r--) s = inv_round(s, rk(br, r), 1'b0);
    return inv_round(s, rk(br, 0), 1'b1);
  endfunction

  assign rnd_result = inv_round(rnd_state, rnd_key, rnd_last);

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances until out_valid is seen; n is the number of edges taken.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    check("out_valid_timeout", 128'(out_valid), 128'd1);
  endtask

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ST0 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;

  logic [KW-1:0] kb;
  logic [127:0]  ct2;
  logic [127:0]  res [2];
  logic [127:0]  exp6;
  int            acc_t [2];
  int            n, bcnt, cyc, acc, got;
  logic          acc_now, seen;

  initial begin
    kb        = expand(KEY);
    ct2       = 128'h0;
    words     = kb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data",  out_data,        128'd0);
    check("rst_rnd_last",  128'(rnd_last),  128'd0);
    check("rst_state",     rnd_state,       128'd0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.1 single block
    in_valid = 1'b1;
    in_data  = CT1;
    tick();
    in_valid = 1'b0;
    check("e0_state",    rnd_state,      ST0);
    check("e0_in_ready", 128'(in_ready), 128'd0);
    check("e0_key9",     rnd_key,        rk(kb, 9));
    bcnt = busy ? 1 : 0;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
      bcnt += busy ? 1 : 0;
      if (n == 9) begin
        check("final_last", 128'(rnd_last), 128'd1);
        check("final_key0", rnd_key,        rk(kb, 0));
      end
    end
    check("latency",    128'(n),    128'd10);
    check("busy_count", 128'(bcnt), 128'd10);
    check("pt1",        out_data,   PT1);
    tick();
    check("drain_valid", 128'(out_valid), 128'd0);
    check("drain_ready", 128'(in_ready),  128'd1);

    // Backpressure, plus foreign in_valid during ROUND
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = CT1;
    tick();
    in_data = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    for (int i = 0; i < 3; i++) tick();
    in_valid = 1'b0;
    wait_out(n);
    check("pt1_ignored", out_data, PT1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold",  out_data,        PT1);
      check("bp_ready", 128'(in_ready),  128'd0);
      check("bp_valid", 128'(out_valid), 128'd1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_drop",  128'(out_valid), 128'd0);
    check("bp_ready", 128'(in_ready),  128'd1);

    // Reset at E5 mid-block
    in_valid = 1'b1;
    in_data  = CT1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_valid", 128'(out_valid), 128'd0);
    check("mrst_data",  out_data,        128'd0);
    check("mrst_ready", 128'(in_ready),  128'd1);
    check("mrst_busy",  128'(busy),      128'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen |= out_valid;
    end
    check("mrst_no_out", 128'(seen), 128'd0);

    // Back-to-back with in_valid held high
    in_valid = 1'b1;
    in_data  = CT1;
    cyc = 0;
    acc = 0;
    got = 0;
    res[0] = '0;
    res[1] = '0;
    acc_t[0] = 0;
    acc_t[1] = 0;
    while (cyc < 60 && got < 2) begin
      acc_now = in_ready && in_valid;
      tick();
      cyc++;
      if (acc_now) begin
        if (acc < 2) acc_t[acc] = cyc;
        acc++;
        if (acc == 1) in_data = ct2;
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        if (got < 2) res[got] = out_data;
        got++;
      end
    end
    in_valid = 1'b0;
    check("b2b_count",   128'(got),                  128'd2);
    check("b2b_spacing", 128'(acc_t[1] - acc_t[0]), 128'd12);
    check("b2b_pt1",     res[0],                     PT1);
    check("b2b_pt2",     res[1],                     dec(ct2, kb, kb));
    tick();

    // Key bundle zeroed after accept
    in_valid = 1'b1;
    in_data  = CT1;
    tick();
    in_valid = 1'b0;
    words    = '0;
    wait_out(n);
`ifdef AES_DEC_KEY_LATCH_EN
    exp6 = PT1;
`else
    exp6 = dec(CT1, kb, '0);
`endif
    check("key_hold", out_data, exp6);
    words = kb;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
